// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM audio DAC and anything that feeds it samples.
package pwm_dac_pkg;

  localparam int DEFAULT_CYCLES_PER_WINDOW = 32'd1024;
  localparam int DEFAULT_CODE_WIDTH        = 32'd10;
  localparam int DEFAULT_FIFO_DEPTH        = 32'd4;

  // Width of a counter that runs 0..cycles-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    return (cycles > 32'd1) ? $clog2(cycles) : 32'd1;
  endfunction

  // Width of a duty register that must hold the full-window value 'cycles'.
  function automatic int duty_width(input int cycles);
    return $clog2(cycles + 32'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = wr_en && !full;
  assign pop_s  = rd_en && !empty;
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array: written on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Read/write pointers; reset flushes the FIFO to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM audio DAC: buffers sample codes and plays one code per PWM window,
// holding the last duty (and flagging underrun) if the buffer runs dry.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int CYCLES_PER_WINDOW = DEFAULT_CYCLES_PER_WINDOW,
  parameter int CODE_WIDTH        = DEFAULT_CODE_WIDTH,
  parameter int FIFO_DEPTH        = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_WIDTH-1:0] code,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic                  pwm,
  output logic                  window_start,
  output logic                  underrun
);

  localparam int CNT_W  = cnt_width(CYCLES_PER_WINDOW);
  localparam int DUTY_W = duty_width(CYCLES_PER_WINDOW);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CYCLES_PER_WINDOW - 32'd1);
  localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(CYCLES_PER_WINDOW);

  logic [CNT_W-1:0]      cnt_r;
  logic [DUTY_W-1:0]     duty_r;
  logic [DUTY_W-1:0]     duty_next_s;
  logic                  pwm_r;
  logic                  window_start_r;
  logic                  underrun_r;
  logic                  wrap_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CODE_WIDTH-1:0] fifo_dout_s;

  assign wrap_s     = (cnt_r == CNT_LAST);
  assign code_ready = !fifo_full_s;
  assign push_s     = code_valid && !fifo_full_s && !rst;
  assign pop_s      = wrap_s && !fifo_empty_s;

  sync_fifo #(
    .WIDTH (CODE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push_s),
    .din   (code),
    .full  (fifo_full_s),
    .rd_en (pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s)
  );

  // Clamp codes above one full window to a constant-high duty.
  always_comb begin
    duty_next_s = DUTY_ZERO;
    if (32'(fifo_dout_s) > 32'(CYCLES_PER_WINDOW)) begin
      duty_next_s = DUTY_FULL;
    end else begin
      duty_next_s = DUTY_W'(fifo_dout_s);
    end
  end

  // Window counter, duty load at window end, sticky underrun and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r          <= CNT_ZERO;
      duty_r         <= DUTY_ZERO;
      pwm_r          <= 1'b0;
      window_start_r <= 1'b0;
      underrun_r     <= 1'b0;
    end else begin
      cnt_r          <= wrap_s ? CNT_ZERO : (cnt_r + CNT_ONE);
      pwm_r          <= (DUTY_W'(cnt_r) < duty_r);
      window_start_r <= (cnt_r == CNT_ZERO);
      if (pop_s) begin
        duty_r <= duty_next_s;
      end
      if (wrap_s && fifo_empty_s) begin
        underrun_r <= 1'b1;
      end
    end
  end

  assign pwm          = pwm_r;
  assign window_start = window_start_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac with an 8-cycle window, 4-bit codes, depth-4 FIFO.
module tb_pwm_dac;

  localparam int C  = 8;
  localparam int CW = 4;
  localparam int D  = 4;

  logic          clk;
  logic          rst;
  logic [CW-1:0] code;
  logic          code_valid;
  logic          code_ready;
  logic          pwm;
  logic          window_start;
  logic          underrun;

  pwm_dac #(
    .CYCLES_PER_WINDOW (C),
    .CODE_WIDTH        (CW),
    .FIFO_DEPTH        (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .code         (code),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .pwm          (pwm),
    .window_start (window_start),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_highs = 0;

  // Reference model: a queue of pending samples and the position within the window.
  int mq[$];
  int m_pos  = 0;
  int m_duty = 0;
  bit m_pwm  = 1'b0;
  bit m_ws   = 1'b0;
  bit m_ur   = 1'b0;

  typedef struct {
    logic [CW-1:0] code;
    int            exp_highs;
  } win_vec_t;

  win_vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [CW-1:0] c);
    bit rdy;
    rdy = (mq.size() < D);
    if (r) begin
      mq.delete();
      m_pos = 0; m_duty = 0; m_pwm = 1'b0; m_ws = 1'b0; m_ur = 1'b0;
    end else begin
      m_pwm = (m_pos < m_duty);
      m_ws  = (m_pos == 0);
      if (m_pos == C - 1) begin
        if (mq.size() > 0) begin
          int x;
          x = mq.pop_front();
          m_duty = (x > C) ? C : x;
        end else begin
          m_ur = 1'b1;
        end
      end
      if (v && rdy) mq.push_back(int'(c));
      m_pos = (m_pos + 1) % C;
    end
  endtask

  // One clock: drive inputs, advance model, sample outputs 1ns after the edge.
  task automatic step(input logic r, input logic v, input logic [CW-1:0] c);
    rst = r; code_valid = v; code = c;
    @(posedge clk);
    model_edge(r, v, c);
    #1;
    check("model_pwm", pwm, m_pwm);
    check("model_window_start", window_start, m_ws);
    check("model_underrun", underrun, m_ur);
    check("model_code_ready", code_ready, (mq.size() < D));
    if (window_start) cur_highs = 0;
    if (pwm) cur_highs++;
  endtask

  logic exp_rdy [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; code_valid = 1'b0; code = '0;
    tbl[0] = '{4'd3, 3};  tbl[1] = '{4'd5, 5};  tbl[2] = '{4'd0, 0};
    tbl[3] = '{4'd8, 8};  tbl[4] = '{4'd15, 8}; tbl[5] = '{4'd9, 8};
    tbl[6] = '{4'd7, 7};  tbl[7] = '{4'd1, 1};

    // Reset with a code presented (must be discarded), then idle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd9);
    check("rst_pwm", pwm, 1'b0);
    check("rst_ws", window_start, 1'b0);
    check("rst_ur", underrun, 1'b0);
    check("rst_ready", code_ready, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 4'd0);
      check("idle_pwm", pwm, 1'b0);
      check("idle_ws", window_start, ((i - 1) % C == 0));
      if (i == 7) check("idle_ur_before", underrun, 1'b0);
      if (i >= 8) check("idle_ur_after", underrun, 1'b1);
    end

    // Table: one code pushed per window, played in the next window.
    step(1'b1, 1'b0, 4'd0);
    for (int k = 0; k <= 8; k++) begin
      for (int j = 0; j < C; j++) begin
        if (j == 0 && k < 8) step(1'b0, 1'b1, tbl[k].code);
        else step(1'b0, 1'b0, 4'd0);
        if (j == 0) check("tbl_ws", window_start, 1'b1);
        if (k > 0) check("tbl_shape", pwm, (j < tbl[k-1].exp_highs));
      end
      if (k > 0) check("tbl_highs", cur_highs, tbl[k-1].exp_highs);
      if (k == 7) check("tbl_no_underrun", underrun, 1'b0);
    end

    // Backpressure: five back-to-back codes in the first window.
    step(1'b1, 1'b0, 4'd0);
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, (i <= 4) ? 4'(i) : 4'd5);
      check("bp_ready", code_ready, exp_rdy[i-1]);
    end
    check("bp_ws", window_start, 1'b1);
    for (int i = 10; i <= 16; i++) step(1'b0, 1'b0, 4'd0);
    check("bp_win2_highs", cur_highs, 1);
    for (int w = 3; w <= 6; w++) begin
      for (int i = 0; i < C; i++) step(1'b0, 1'b0, 4'd0);
      check("bp_win_highs", cur_highs, w - 1);
    end

    // Underrun hold: single code 6, then nothing.
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd6);
    for (int i = 2; i <= 15; i++) step(1'b0, 1'b0, 4'd0);
    check("uh_ur_before", underrun, 1'b0);
    step(1'b0, 1'b0, 4'd0);
    check("uh_ur_after", underrun, 1'b1);
    check("uh_win2_highs", cur_highs, 6);
    for (int i = 17; i <= 24; i++) step(1'b0, 1'b0, 4'd0);
    check("uh_win3_highs", cur_highs, 6);
    check("uh_ur_sticky", underrun, 1'b1);

    // Mid-window reset at cnt == 3 while duty 7 is playing.
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd7);
    for (int i = 2; i <= 11; i++) step(1'b0, 1'b0, 4'd0);
    check("mr_pwm_before", pwm, 1'b1);
    step(1'b1, 1'b1, 4'd9);
    check("mr_pwm", pwm, 1'b0);
    check("mr_ws", window_start, 1'b0);
    check("mr_ur", underrun, 1'b0);
    check("mr_ready", code_ready, 1'b1);
    step(1'b0, 1'b0, 4'd0);
    check("mr_ws_after", window_start, 1'b1);
    check("mr_pwm_after", pwm, 1'b0);
    for (int i = 14; i <= 20; i++) step(1'b0, 1'b0, 4'd0);
    check("mr_win1_highs", cur_highs, 0);
    check("mr_ur_first_end", underrun, 1'b1);
    for (int i = 21; i <= 28; i++) step(1'b0, 1'b0, 4'd0);
    check("mr_win2_highs", cur_highs, 0);

    // Randomized traffic with occasional resets, dense then sparse.
    step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic v;
      r = ($urandom_range(0, 99) == 0);
      v = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      step(r, v, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
